// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the baud-tick divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    // Clock cycles per oversample tick, rounded to the nearest integer.
    function automatic int uart_div(input int clkHz, input int baud);
        return (clkHz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO (pointer plus occupancy count). A push into a full
// FIFO is accepted only when a pop happens in the same cycle. Storage is
// cleared on reset so the head output reads zero while empty after reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_CNT);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign dout   = mem_q[rdPtr_q];

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= din;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, 16x oversample tick,
// start/data/stop FSM with glitch rejection and break handling, and a
// small output FIFO behind a valid/ready handshake.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       frame_err,
    output logic       overrun
);

    import uart_pkg::*;

    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);

    logic          rxMeta_q;
    logic          rxSync_q;
    logic [TW-1:0] tickCnt_q;
    logic [TW-1:0] tickCnt_d;
    logic          tick;
    rx_state_t     state_q;
    logic [3:0]    scnt_q;
    logic [2:0]    bidx_q;
    logic [7:0]    shift_q;
    logic          frameErr_q;
    logic          overrun_q;
    logic          push;
    logic          popFire;
    logic          fifoFull;
    logic          fifoEmpty;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rxd;
            rxSync_q <= rxMeta_q;
        end
    end

    assign tick = (tickCnt_q == DIV_LAST);

    // Free-running divider: next count wraps to zero on the tick cycle.
    always_comb begin
        tickCnt_d = tickCnt_q + 1'b1;
        if (tick) begin
            tickCnt_d = '0;
        end
    end

    // Divider register, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            tickCnt_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_d;
        end
    end

    // A good stop bit pushes straight into the FIFO on the sample tick so the byte is visible next cycle.
    assign push    = (state_q == STOP) && tick && (scnt_q == 4'd15) && rxSync_q;
    assign popFire = out_valid && out_ready;

    // Receive FSM with sample counter, bit index, shift register and registered error pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            scnt_q     <= '0;
            bidx_q     <= '0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            overrun_q  <= push && fifoFull && !popFire;
            case (state_q)
                IDLE: begin
                    if (!rxSync_q) begin
                        state_q <= START;
                        scnt_q  <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (scnt_q == 4'd7) begin
                            if (!rxSync_q) begin
                                state_q <= DATA;
                                scnt_q  <= '0;
                                bidx_q  <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == 4'd15) begin
                            shift_q <= {rxSync_q, shift_q[7:1]};
                            bidx_q  <= bidx_q + 1'b1;
                            if (bidx_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == 4'd15) begin
                            if (rxSync_q) begin
                                state_q <= IDLE;
                            end else begin
                                frameErr_q <= 1'b1;
                                state_q    <= BREAK;
                            end
                        end
                    end
                end
                BREAK: begin
                    if (rxSync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) rxFifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (shift_q),
        .full  (fifoFull),
        .pop   (popFire),
        .dout  (out_data),
        .empty (fifoEmpty)
    );

    assign out_valid = !fifoEmpty;
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic
// with jittered bit periods, checked against a queue model of the bytes
// the line carries.
module tb_uart_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD_R = 10_000;
    localparam int DIVT   = 10;
    localparam int BIT    = 160;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int passes = 0;
    int feCnt = 0;
    int ovCnt = 0;
    int edgeN = 0;
    logic [7:0] expQ[$];
    logic [7:0] recvLog[$];

    uart_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rxd       (rxd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // 10-unit clock period
    always #5 clock = ~clock;

    // Edges since reset release; the oversample tick falls on multiples of the divisor
    always @(posedge clock) begin
        if (reset) edgeN <= 0;
        else       edgeN <= edgeN + 1;
    end

    // Hard time limit so a stuck run still ends
    initial begin
        #1_200_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic failNow(input string name, input string what);
        checks++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    task automatic sendBit(input logic v, input int cycles);
        rxd = v;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic idleLine(input int cycles);
        rxd = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    // One 8N1 frame; a bad frame holds the stop bit low for two bit times first
    task automatic applyStimulus(input logic [7:0] b, input int period, input logic badStop);
        sendBit(1'b0, period);
        for (int i = 0; i < 8; i++) sendBit(b[i], period);
        if (badStop) sendBit(1'b0, 2 * period);
        sendBit(1'b1, period);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((expQ.size() != 0 || out_valid) && n < 4000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 4000) failNow(name, $sformatf("still %0d bytes pending, required 0", expQ.size()));
        else checkOutput(name, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int base;
        int badCount;
        int feBase;
        logic randDone;
        logic [7:0] rb;
        int rp;
        logic rbad;
        logic [7:0] partial;

        // Compare process: every accepted byte against the model, hold stability, pulse counting
        fork
            begin : monitor
                logic prevHold;
                logic [7:0] prevData;
                prevHold = 1'b0;
                prevData = '0;
                forever begin
                    @(negedge clock);
                    if (frame_err) feCnt++;
                    if (overrun) ovCnt++;
                    if (!reset) begin
                        if (prevHold) begin
                            checkOutput("hold valid", {31'd0, out_valid}, 32'd1);
                            checkOutput("hold data", {24'd0, out_data}, {24'd0, prevData});
                        end
                        if (out_valid && out_ready) begin
                            recvLog.push_back(out_data);
                            if (expQ.size() == 0)
                                failNow("rx byte", $sformatf("got 0x%0h, required no byte", out_data));
                            else
                                checkOutput("rx byte", {24'd0, out_data}, {24'd0, expQ.pop_front()});
                        end
                    end
                    prevHold = !reset && out_valid && !out_ready;
                    prevData = out_data;
                end
            end
        join_none

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset out_data", {24'd0, out_data}, 32'd0);
        checkOutput("reset frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        idleLine(50);

        // Single byte
        $display("[TB] single byte");
        out_ready = 1'b1;
        expQ.push_back(8'hA5);
        applyStimulus(8'hA5, BIT, 1'b0);
        idleLine(100);
        waitDrain("single drain");
        checkOutput("single count", recvLog.size(), 32'd1);
        checkOutput("single data", {24'd0, recvLog[0]}, 32'hA5);
        checkOutput("single no frame_err", feCnt, 32'd0);
        checkOutput("single no overrun", ovCnt, 32'd0);

        // Glitch rejection
        $display("[TB] glitch");
        sendBit(1'b0, 40);
        idleLine(400);
        checkOutput("glitch no byte", recvLog.size(), 32'd1);
        checkOutput("glitch out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("glitch no frame_err", feCnt, 32'd0);

        // Framing error then recovery
        $display("[TB] framing error");
        applyStimulus(8'h3C, BIT, 1'b1);
        idleLine(200);
        checkOutput("frame_err pulses", feCnt, 32'd1);
        checkOutput("frame_err fifo empty", {31'd0, out_valid}, 32'd0);
        expQ.push_back(8'h55);
        applyStimulus(8'h55, BIT, 1'b0);
        idleLine(100);
        waitDrain("after framing drain");
        checkOutput("after framing data", {24'd0, recvLog[recvLog.size() - 1]}, 32'h55);

        // Overrun: five back-to-back bytes into a four-entry FIFO
        $display("[TB] overrun");
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) expQ.push_back(8'(i));
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), BIT, 1'b0);
        idleLine(100);
        checkOutput("overrun pulses", ovCnt, 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput("burst valid", {31'd0, out_valid}, 32'd1);
            checkOutput("burst data", {24'd0, out_data}, i);
            @(posedge clock);
            #1;
        end
        checkOutput("burst empty", {31'd0, out_valid}, 32'd0);

        // Full FIFO with a pop in the exact cycle of the fifth push
        $display("[TB] full plus pop");
        out_ready = 1'b0;
        base = recvLog.size();
        for (int i = 0; i < 5; i++) expQ.push_back(8'h11 + 8'(i));
        for (int i = 0; i < 4; i++) applyStimulus(8'h11 + 8'(i), BIT, 1'b0);
        fork
            applyStimulus(8'h15, BIT, 1'b0);
            begin : popAtPush
                int a;
                int t1;
                int tPush;
                a = edgeN;
                t1 = a + 4;
                while (t1 % DIVT != 0) t1++;
                tPush = t1 + 7 * DIVT + 9 * 16 * DIVT;
                while (edgeN < tPush - 1) begin
                    @(posedge clock);
                    #1;
                end
                out_ready = 1'b1;
                @(posedge clock);
                #1;
                out_ready = 1'b0;
            end
        join
        idleLine(100);
        checkOutput("full+pop no overrun", ovCnt, 32'd1);
        waitDrain("full+pop drain");
        checkOutput("full+pop count", recvLog.size() - base, 32'd5);
        for (int i = 0; i < 5; i++)
            checkOutput("full+pop order", {24'd0, recvLog[base + i]}, 32'h11 + i);

        // Reset during bit 3 of a frame, with an unread byte already buffered
        $display("[TB] reset mid-frame");
        out_ready = 1'b0;
        expQ.push_back(8'h5A);
        applyStimulus(8'h5A, BIT, 1'b0);
        idleLine(100);
        checkOutput("pre-reset valid", {31'd0, out_valid}, 32'd1);
        feBase = feCnt;
        partial = 8'h96;
        sendBit(1'b0, BIT);
        for (int i = 0; i < 3; i++) sendBit(partial[i], BIT);
        sendBit(partial[3], 80);
        reset = 1'b1;
        rxd = 1'b1;
        expQ.delete();
        @(posedge clock);
        #1;
        checkOutput("mid-reset valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid-reset data", {24'd0, out_data}, 32'd0);
        reset = 1'b0;
        idleLine(300);
        checkOutput("post-reset idle", {31'd0, out_valid}, 32'd0);
        checkOutput("post-reset no frame_err", feCnt, feBase);
        out_ready = 1'b1;
        expQ.push_back(8'hFF);
        applyStimulus(8'hFF, BIT, 1'b0);
        idleLine(100);
        waitDrain("post-reset drain");
        checkOutput("post-reset data", {24'd0, recvLog[recvLog.size() - 1]}, 32'hFF);

        // Randomized traffic: random bytes, +/-2% bit period, occasional broken stop bit
        $display("[TB] random traffic");
        feBase = feCnt;
        badCount = 0;
        randDone = 1'b0;
        fork
            begin
                for (int f = 0; f < 16; f++) begin
                    rb = 8'($urandom);
                    rp = $urandom_range(157, 163);
                    rbad = ($urandom_range(0, 5) == 0);
                    if (rbad) badCount++;
                    else expQ.push_back(rb);
                    applyStimulus(rb, rp, rbad);
                    idleLine($urandom_range(0, 200));
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        idleLine(50);
        waitDrain("random drain");
        checkOutput("random frame_err count", feCnt - feBase, badCount);
        checkOutput("random no overrun", ovCnt, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
